// File: rtl/regfile_mp.sv
// Two-read / two-write register file with a sequential clear engine.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle write data to reads.
module regfile_mp #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic [AW-1:0] rna,
  input  logic [AW-1:0] rnb,
  output logic [DW-1:0] qa,
  output logic [DW-1:0] qb,
  input  logic          we0,
  input  logic [AW-1:0] wn0,
  input  logic [DW-1:0] d0,
  input  logic          we1,
  input  logic [AW-1:0] wn1,
  input  logic [DW-1:0] d1,
  input  logic          clr,
  output logic          clr_busy,
  output logic          wcoll
);

  localparam int            DEPTH   = 2 ** AW;
  localparam logic [0:0]    S_IDLE  = 1'b0;
  localparam logic [0:0]    S_CLEAR = 1'b1;
  localparam logic [AW-1:0] IDX_LAST  = {AW{1'b1}};
  localparam logic [AW-1:0] IDX_FIRST =
    (ZERO_REG != 0) ? AW'(1) : AW'(0);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [0:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          wcoll_q, wcoll_d;
  logic          busy;
  logic          ok0, ok1;

  assign busy = (state_q == S_CLEAR);
  assign ok0  = we0 && !((ZERO_REG != 0) && (wn0 == '0));
  assign ok1  = we1 && !((ZERO_REG != 0) && (wn1 == '0));

  always_comb begin
    mem_d = mem_q;
    if (busy) begin
      mem_d[idx_q] = '0;
    end else begin
      // port 1 is applied last so it wins a same-address collision
      if (ok0) mem_d[wn0] = d0;
      if (ok1) mem_d[wn1] = d1;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (clr) begin
          state_d = S_CLEAR;
          idx_d   = IDX_FIRST;
        end
      end
      default: begin
        if (idx_q == IDX_LAST) begin
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
    endcase
  end

  assign wcoll_d = !busy && ok0 && ok1 && (wn0 == wn1);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      mem_q   <= '{default: '0};
      state_q <= S_IDLE;
      idx_q   <= '0;
      wcoll_q <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      wcoll_q <= wcoll_d;
    end
  end

  always_comb begin
    qa = mem_q[rna];
`ifdef REGFILE_MP_BYPASS_EN
    if (!busy) begin
      if (we1 && wn1 == rna)      qa = d1;
      else if (we0 && wn0 == rna) qa = d0;
    end
`endif
    if ((ZERO_REG != 0) && (rna == '0)) qa = '0;
  end

  always_comb begin
    qb = mem_q[rnb];
`ifdef REGFILE_MP_BYPASS_EN
    if (!busy) begin
      if (we1 && wn1 == rnb)      qb = d1;
      else if (we0 && wn0 == rnb) qb = d0;
    end
`endif
    if ((ZERO_REG != 0) && (rnb == '0)) qb = '0;
  end

  assign clr_busy = busy;
  assign wcoll    = wcoll_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed testbench for regfile_mp (default parameters).
// Handles both builds of REGFILE_MP_BYPASS_EN.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        clrn;
  logic [4:0]  rna, rnb, wn0, wn1;
  logic [31:0] qa, qb, d0, d1;
  logic        we0, we1, clr, clr_busy, wcoll;

  int checks   = 0;
  int failures = 0;
  int k;

  regfile_mp dut (
    .clk(clk), .clrn(clrn),
    .rna(rna), .rnb(rnb), .qa(qa), .qb(qb),
    .we0(we0), .wn0(wn0), .d0(d0),
    .we1(we1), .wn1(wn1), .d1(d1),
    .clr(clr), .clr_busy(clr_busy), .wcoll(wcoll)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clrn = 1'b1;
    rna = '0; rnb = '0;
    we0 = 1'b0; wn0 = '0; d0 = '0;
    we1 = 1'b0; wn1 = '0; d1 = '0;
    clr = 1'b0;
    #2 clrn = 1'b0;
    #10;
    chk("rst_busy", {31'd0, clr_busy}, 32'd0);
    chk("rst_wcoll", {31'd0, wcoll}, 32'd0);
    clrn = 1'b1;
    #1;
    for (int a = 0; a < 32; a++) begin
      rna = 5'(a); rnb = 5'(31 - a);
      #1;
      chk("rst_qa", qa, 32'd0);
      chk("rst_qb", qb, 32'd0);
    end

    // basic write / read, and write to entry 0 discarded
    step;
    we0 = 1'b1; wn0 = 5'd5; d0 = 32'hDEADBEEF;
    step;
    we0 = 1'b0; rna = 5'd5;
    #1 chk("wr5", qa, 32'hDEADBEEF);
    we0 = 1'b1; wn0 = 5'd0; d0 = 32'h1234;
    step;
    we0 = 1'b0; rna = 5'd0;
    #1 chk("wr0", qa, 32'd0);

    // same-address collision: port 1 wins, wcoll one cycle
    we0 = 1'b1; wn0 = 5'd7; d0 = 32'h1;
    we1 = 1'b1; wn1 = 5'd7; d1 = 32'h2;
    step;
    we0 = 1'b0; we1 = 1'b0; rna = 5'd7;
    #1 chk("coll_data", qa, 32'h2);
    chk("coll_w1", {31'd0, wcoll}, 32'd1);
    step;
    chk("coll_w0", {31'd0, wcoll}, 32'd0);

    // collision on entry 0 is not flagged
    we0 = 1'b1; wn0 = 5'd0; we1 = 1'b1; wn1 = 5'd0;
    step;
    we0 = 1'b0; we1 = 1'b0;
    chk("coll_z", {31'd0, wcoll}, 32'd0);

    // different addresses, both commit, no collision
    we0 = 1'b1; wn0 = 5'd11; d0 = 32'hAAAA0011;
    we1 = 1'b1; wn1 = 5'd12; d1 = 32'hBBBB0012;
    step;
    we0 = 1'b0; we1 = 1'b0; rna = 5'd11; rnb = 5'd12;
    #1 chk("dual_a", qa, 32'hAAAA0011);
    chk("dual_b", qb, 32'hBBBB0012);
    chk("dual_w", {31'd0, wcoll}, 32'd0);

    // fill 1..31 with their index
    for (int i = 1; i < 32; i++) begin
      we0 = 1'b1; wn0 = 5'(i); d0 = 32'(i);
      step;
    end
    we0 = 1'b0;
    rna = 5'd20; rnb = 5'd31;
    #1 chk("fill20", qa, 32'd20);
    chk("fill31", qb, 32'd31);

    // sequential clear: busy cycle k clears entry k
    clr = 1'b1;
    step;
    clr = 1'b0;
    k = 0;
    while (clr_busy && k < 100) begin
      k++;
      rna = 5'd20;
      if (k == 10) begin
        we0 = 1'b1; wn0 = 5'd3; d0 = 32'h55;
        we1 = 1'b1; wn1 = 5'd3; d1 = 32'h66;
      end
      if (k == 11) begin
        we0 = 1'b0; we1 = 1'b0; rna = 5'd3;
      end
      if (k == 15) clr = 1'b1;
      if (k == 16) clr = 1'b0;
      #1;
      if (k == 5)  chk("clr_keep20", qa, 32'd20);
      if (k == 20) chk("clr_pre20", qa, 32'd20);
      if (k == 21) chk("clr_post20", qa, 32'd0);
      if (k == 11) begin
        chk("clr_drop3", qa, 32'd0);
        chk("clr_wcoll", {31'd0, wcoll}, 32'd0);
      end
      step;
    end
    chk("clr_len", 32'(k), 32'd31);
    for (int a = 0; a < 32; a++) begin
      rna = 5'(a);
      #1 chk("clr_all", qa, 32'd0);
    end

    // reset in the middle of a clear
    we0 = 1'b1; wn0 = 5'd30; d0 = 32'hCAFE0030;
    step;
    we0 = 1'b0;
    clr = 1'b1;
    step;
    clr = 1'b0;
    k = 1;
    while (k < 10) begin
      step;
      k++;
    end
    chk("mid_busy_pre", {31'd0, clr_busy}, 32'd1);
    rna = 5'd30;
    #1 chk("mid_keep30", qa, 32'hCAFE0030);
    clrn = 1'b0;
    #1;
    chk("mid_rst30", qa, 32'd0);
    chk("mid_busy", {31'd0, clr_busy}, 32'd0);
    #1 clrn = 1'b1;
    clr = 1'b1;
    step;
    clr = 1'b0;
    k = 0;
    while (clr_busy && k < 100) begin
      k++;
      step;
    end
    chk("rst_clr_len", 32'(k), 32'd31);

    // same-cycle write visibility
    we0 = 1'b1; wn0 = 5'd9; d0 = 32'h11;
    step;
    we0 = 1'b0;
    we1 = 1'b1; wn1 = 5'd9; d1 = 32'hA5A5A5A5; rnb = 5'd9;
    #1;
`ifdef REGFILE_MP_BYPASS_EN
    chk("byp_pre", qb, 32'hA5A5A5A5);
`else
    chk("byp_pre", qb, 32'h11);
`endif
    step;
    we1 = 1'b0;
    #1 chk("byp_post", qb, 32'hA5A5A5A5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the pipelined CPU. Successor to the single-write, two-read file.
- Two read ports and two write ports. Width and depth are configurable. Entry 0 can be hard-wired to zero.
- Adds a sequential clear engine (one entry per cycle, with a busy flag) so software or the pipeline can zero the file without asserting the global reset.
- Same-cycle write-to-read bypass is available as a compile-time option.

Parameters:
- DW, 32, data width in bits.
- AW, 5, address width; depth = 2**AW entries.
- ZERO_REG, 1, when 1 entry 0 always reads 0 and is never written.

Ports:
- clk  in  1  clock; all writes and FSM updates on rising edge.
- clrn  in  1  asynchronous active-low reset.
- rna  in  AW  read address, port A.
- rnb  in  AW  read address, port B.
- qa  out  DW  read data, port A (combinational).
- qb  out  DW  read data, port B (combinational).
- we0  in  1  write enable, port 0.
- wn0  in  AW  write address, port 0.
- d0  in  DW  write data, port 0.
- we1  in  1  write enable, port 1.
- wn1  in  AW  write address, port 1.
- d1  in  DW  write data, port 1.
- clr  in  1  single-cycle request to start a sequential clear.
- clr_busy  out  1  high while the clear engine is running.
- wcoll  out  1  registered; high for one cycle after both ports wrote the same address.

Behaviour:
- Reset (clrn=0, asynchronous):
  - all entries become 0.
  - FSM goes to IDLE; clear index = 0.
  - clr_busy=0, wcoll=0.
  - qa/qb therefore read 0.
- Reads are combinational from the array.
  - With ZERO_REG=1, an address of 0 returns 0 regardless of array contents or bypass.
- Writes are committed on the rising clk edge when the corresponding weN=1.
  - With ZERO_REG=1, writes to address 0 are discarded.
- Simultaneous writes to the same address (we0=we1=1, wn0==wn1):
  - port 1 wins.
  - wcoll=1 on the next cycle, else 0.
  - wcoll is not raised when the common address is 0 and ZERO_REG=1.
- Clear FSM, two states, IDLE and CLEAR:
  - IDLE: when clr=1, go to CLEAR and load idx = (ZERO_REG ? 1 : 0). clr_busy rises on the same edge.
  - CLEAR: each cycle write 0 to entry idx, then idx = idx+1.
  - When idx == 2**AW-1 is written, return to IDLE and drop clr_busy on that edge.
  - Clear duration is 2**AW-ZERO_REG cycles (31 for the defaults).
  - clr asserted while in CLEAR is ignored; there is no restart.
  - While in CLEAR, functional writes (we0/we1) are dropped and wcoll is held 0.
  - While in CLEAR, reads return current array contents: entries not yet cleared keep their old values. The pipeline must stall on clr_busy.
- idx is AW bits wide and must not wrap past the last entry. The FSM exits exactly on the last entry.
- clrn asserted mid-clear: the array zeroes immediately and the FSM returns to IDLE. No partial state survives.
- All outputs are free of X after reset. Address inputs are full-range, with no out-of-range case.

Optional Feature:
- Macro REGFILE_MP_BYPASS_EN.
- Defined: qa/qb forward same-cycle write data before the edge.
  - If we1=1 and wn1 matches the read address, return d1.
  - Else if we0=1 and wn0 matches, return d0.
  - Else return array contents.
  - Priority matches commit priority.
  - No forwarding on address 0 when ZERO_REG=1.
  - No forwarding while clr_busy=1.
- Undefined: reads return only committed array contents. A same-cycle write is visible one cycle later.

Test Plan:
- Reset, then read all addresses -> every read returns 0; clr_busy=0, wcoll=0.
- we0=1, wn0=5, d0=32'hDEADBEEF; next cycle rna=5 -> qa=32'hDEADBEEF. Write wn0=0, d0=32'h1234 -> reading address 0 returns 0 (ZERO_REG=1).
- we0=we1=1, wn0=wn1=7, d0=32'h1, d1=32'h2 -> entry 7 = 32'h2; wcoll=1 for exactly one cycle.
- Fill entries 1..31 with their index. Pulse clr -> clr_busy high for exactly 31 cycles. During clear, entry 20 reads 20 until it is cleared. we0 to address 3 mid-clear is dropped. After clear all entries read 0.
- Start clear, assert clrn=0 at the 10th busy cycle -> all entries read 0 immediately; clr_busy=0; a new clr restarts a full 31-cycle clear.
- With REGFILE_MP_BYPASS_EN: we1=1, wn1=9, d1=32'hA5A5A5A5, rnb=9 in the same cycle -> qb=32'hA5A5A5A5 before the edge. Without the macro, qb shows the old value until after the edge.
